// File: rtl/spi_flash_driver.sv
// SPI master PHY: runs one flash operation per CS-low frame (command/address bits, then
// write-byte streaming or read-byte capture), CPHA=0 with configurable idle polarity.
module spi_flash_driver #(
    parameter int unsigned P_OPERATION_WIDTH  = 32,
    parameter int unsigned P_WRITE_DATA_WIDTH = 8,
    parameter int unsigned P_READ_DATA_WIDTH  = 8,
    parameter bit          P_CPOL             = 1'b0,
    parameter int unsigned P_SCK_HALF         = 2,
    parameter int unsigned P_CS_GAP           = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [P_OPERATION_WIDTH-1:0]  i_user_op_data,
    input  logic [1:0]                    i_user_op_type,
    input  logic [15:0]                   i_user_op_data_len,
    input  logic [15:0]                   i_user_op_clk_len,
    input  logic                          i_user_op_valid,
    output logic                          o_user_op_ready,
    input  logic [P_WRITE_DATA_WIDTH-1:0] i_user_write_data,
    output logic                          o_user_write_req,
    output logic [P_READ_DATA_WIDTH-1:0]  o_user_read_data,
    output logic                          o_user_read_valid,
    output logic                          o_spi_clk,
    output logic                          o_spi_cs,
    output logic                          o_spi_mosi,
    input  logic                          i_spi_miso
);

    localparam int unsigned OW = P_OPERATION_WIDTH;
    localparam int unsigned WW = P_WRITE_DATA_WIDTH;
    localparam int unsigned RW = P_READ_DATA_WIDTH;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    localparam logic [1:0]  OP_READ   = 2'd1;
    localparam logic [1:0]  OP_WRITE  = 2'd2;
    localparam logic [15:0] HALF_LAST = 16'(P_SCK_HALF - 1);
    localparam logic [15:0] GAP_LAST  = 16'(P_CS_GAP - 1);

    logic [2:0]    state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          half_q, half_d;
    logic [15:0]   bit_q, bit_d;
    logic [OW-1:0] op_q, op_d;
    logic [1:0]    type_q, type_d;
    logic [15:0]   dlen_q, dlen_d;
    logic [15:0]   clen_q, clen_d;
    logic          mosi_q, mosi_d;
    logic          sck_q, sck_d;
    logic          cs_q, cs_d;
    logic [WW-1:0] wr_sh_q, wr_sh_d;
    logic          wr_load_q, wr_load_d;
    logic [RW-1:0] rd_sh_q, rd_sh_d;
    logic [15:0]   rd_cnt_q, rd_cnt_d;
    logic [RW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;

    logic          lead;
    logic [15:0]   pos;
    logic [15:0]   dlen_clamp;
    logic          wr_req;
    logic          rd_take;

    assign dlen_clamp = (i_user_op_data_len > 16'(OW)) ? 16'(OW) : i_user_op_data_len;
    // First cycle with SCK at its active level: the leading-edge cycle of bit bit_q.
    assign lead       = (state_q == ST_SHIFT) && !half_q && (cnt_q == 16'd0);
    assign pos        = bit_q + 16'd1 - dlen_q;

    // Request the byte whose first bit follows bit_q, only if the whole byte fits in the frame.
    // With data_len=0 the first byte has no preceding bit, so it is requested at SETUP entry.
    assign wr_req = (type_q == OP_WRITE) &&
                    ((lead && ({1'b0, bit_q} + 17'd1 >= {1'b0, dlen_q}) &&
                      ((pos % 16'(WW)) == 16'd0) &&
                      ({1'b0, bit_q} + 17'(WW + 1) <= {1'b0, clen_q})) ||
                     ((state_q == ST_SETUP) && (cnt_q == 16'd0) && (dlen_q == 16'd0) &&
                      (clen_q >= 16'(WW))));
    assign rd_take = (type_q == OP_READ) && lead && (bit_q >= dlen_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        half_d     = half_q;
        bit_d      = bit_q;
        op_d       = op_q;
        type_d     = type_q;
        dlen_d     = dlen_q;
        clen_d     = clen_q;
        mosi_d     = mosi_q;
        wr_sh_d    = wr_sh_q;
        wr_load_d  = wr_req;
        rd_sh_d    = rd_sh_q;
        rd_cnt_d   = rd_cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        if (wr_load_q) begin
            wr_sh_d = i_user_write_data;
            if (state_q == ST_SETUP) begin
                mosi_d  = i_user_write_data[WW-1];
                wr_sh_d = i_user_write_data << 1;
            end
        end

        if (rd_take) begin
            rd_sh_d  = {rd_sh_q[RW-2:0], i_spi_miso};
            rd_cnt_d = rd_cnt_q + 16'd1;
            if (rd_cnt_q == 16'(RW - 1)) begin
                rd_cnt_d   = 16'd0;
                rd_data_d  = {rd_sh_q[RW-2:0], i_spi_miso};
                rd_valid_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (i_user_op_valid) begin
                    state_d  = ST_SETUP;
                    cnt_d    = 16'd0;
                    half_d   = 1'b0;
                    bit_d    = 16'd0;
                    op_d     = i_user_op_data;
                    type_d   = i_user_op_type;
                    dlen_d   = dlen_clamp;
                    clen_d   = i_user_op_clk_len;
                    mosi_d   = (dlen_clamp != 16'd0) && i_user_op_data[OW-1];
                    wr_sh_d  = '0;
                    rd_cnt_d = 16'd0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = (clen_q == 16'd0) ? ST_HOLD : ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != HALF_LAST) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d  = 16'd0;
                    half_d = ~half_q;
                    if (!half_q) begin
                        // Trailing edge: launch bit bit_q+1 (uses wr_sh_d so a same-cycle load counts).
                        op_d = op_q << 1;
                        if ({1'b0, bit_q} + 17'd1 < {1'b0, dlen_q}) begin
                            mosi_d = op_q[OW-2];
                        end else begin
                            mosi_d  = wr_sh_d[WW-1];
                            wr_sh_d = wr_sh_d << 1;
                        end
                    end else begin
                        bit_d = bit_q + 16'd1;
                        if (bit_q == clen_q - 16'd1) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = ST_GAP;
                    mosi_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        sck_d = P_CPOL ^ ((state_d == ST_SHIFT) && !half_d);
        cs_d  = !((state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 16'd0;
            half_q     <= 1'b0;
            bit_q      <= 16'd0;
            op_q       <= '0;
            type_q     <= 2'd0;
            dlen_q     <= 16'd0;
            clen_q     <= 16'd0;
            mosi_q     <= 1'b0;
            sck_q      <= P_CPOL;
            cs_q       <= 1'b1;
            wr_sh_q    <= '0;
            wr_load_q  <= 1'b0;
            rd_sh_q    <= '0;
            rd_cnt_q   <= 16'd0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            bit_q      <= bit_d;
            op_q       <= op_d;
            type_q     <= type_d;
            dlen_q     <= dlen_d;
            clen_q     <= clen_d;
            mosi_q     <= mosi_d;
            sck_q      <= sck_d;
            cs_q       <= cs_d;
            wr_sh_q    <= wr_sh_d;
            wr_load_q  <= wr_load_d;
            rd_sh_q    <= rd_sh_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign o_user_op_ready   = (state_q == ST_IDLE);
    assign o_user_write_req  = wr_req;
    assign o_user_read_data  = rd_data_q;
    assign o_user_read_valid = rd_valid_q;
    assign o_spi_clk         = sck_q;
    assign o_spi_cs          = cs_q;
    assign o_spi_mosi        = mosi_q;

endmodule
